// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the fetch sequencer, its byte-wide instruction
// memory, the decode stage and the redirect/start sources.
interface fetch_sequencer_if #(
  parameter int DATA_WID = 64
);
  logic                start;
  logic [DATA_WID-1:0] start_pc;
  logic                redirect_valid;
  logic [DATA_WID-1:0] redirect_pc;
  logic                mem_en;
  logic [DATA_WID-1:0] mem_addr;
  logic [7:0]          mem_rdata;
  logic                instr_valid;
  logic                instr_ready;
  logic [3:0]          icode;
  logic [3:0]          ifun;
  logic [3:0]          rA;
  logic [3:0]          rB;
  logic [DATA_WID-1:0] valC;
  logic [DATA_WID-1:0] valP;
  logic                halt;
  logic                imem_error;

  modport master (
    input  start, start_pc, redirect_valid, redirect_pc, mem_rdata, instr_ready,
    output mem_en, mem_addr, instr_valid, icode, ifun, rA, rB, valC, valP, halt, imem_error
  );

  modport slave (
    output start, start_pc, redirect_valid, redirect_pc, mem_rdata, instr_ready,
    input  mem_en, mem_addr, instr_valid, icode, ifun, rA, rB, valC, valP, halt, imem_error
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Multi-cycle Y86-64 fetch controller: streams one byte per cycle from a
// byte-wide synchronous memory and assembles the instruction fields for decode.
module fetch_sequencer #(
  parameter int DATA_WID  = 64,
  parameter int MEM_BYTES = 2048
) (
  input logic               clk,
  input logic               rst,
  fetch_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    HOLD   = 3'd2,
    HALTED = 3'd3,
    ERROR  = 3'd4
  } state_t;

  localparam logic [DATA_WID-1:0] MEM_LIMIT = DATA_WID'(MEM_BYTES);

  // Instruction length in bytes; 0 flags an invalid icode.
  function automatic logic [3:0] instr_len(input logic [3:0] code);
    case (code)
      4'h0, 4'h1, 4'h9:       instr_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
      4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
      4'h7, 4'h8:             instr_len = 4'd9;
      default:                instr_len = 4'd0;
    endcase
  endfunction

  state_t              state_r, state_nx;
  logic [DATA_WID-1:0] pc_r;
  logic [3:0]          cnt_r;
  logic [3:0]          len_r;
  logic [3:0]          icode_r, ifun_r, ra_r, rb_r;
  logic [DATA_WID-1:0] valc_r, valp_r;
  logic                valid_r, halt_r, err_r;

  logic                cap_s, want_s, range_err_s, bad_icode_s, done_s, hs_s;
  logic                restart_s, mem_en_s;
  logic [3:0]          cur_len_s;
  logic [2:0]          valc_k_s;
  logic [DATA_WID-1:0] rd_addr_s, restart_pc_s;

  // Fetch datapath control; cnt_r counts reads issued, so byte cnt_r-1 is on mem_rdata.
  always_comb begin
    cap_s       = (state_r == FETCH) && (cnt_r != 4'd0);
    cur_len_s   = (cnt_r == 4'd1) ? instr_len(bus.mem_rdata[7:4]) : len_r;
    bad_icode_s = cap_s && (cnt_r == 4'd1) && (cur_len_s == 4'd0);
    want_s      = (state_r == FETCH) && ((cnt_r == 4'd0) || (cnt_r < cur_len_s));
    rd_addr_s   = pc_r + {{(DATA_WID-4){1'b0}}, cnt_r};
    range_err_s = want_s && (rd_addr_s >= MEM_LIMIT);
    done_s      = cap_s && (cur_len_s != 4'd0) && (cnt_r == cur_len_s);
    hs_s        = (state_r == HOLD) && valid_r && bus.instr_ready;
    valc_k_s    = (cur_len_s == 4'd10) ? 3'(cnt_r - 4'd3) : 3'(cnt_r - 4'd2);
    if ((state_r != IDLE) && bus.redirect_valid) begin
      restart_s    = 1'b1;
      restart_pc_s = bus.redirect_pc;
    end else if (((state_r == IDLE) || (state_r == HALTED) || (state_r == ERROR)) && bus.start) begin
      restart_s    = 1'b1;
      restart_pc_s = bus.start_pc;
    end else begin
      restart_s    = 1'b0;
      restart_pc_s = '0;
    end
    mem_en_s = want_s && !range_err_s && !restart_s;
  end

  // Next-state selection.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (restart_s) state_nx = FETCH;
        else           state_nx = IDLE;
      end
      FETCH: begin
        if (restart_s)                        state_nx = FETCH;
        else if (bad_icode_s || range_err_s)  state_nx = ERROR;
        else if (done_s)                      state_nx = HOLD;
        else                                  state_nx = FETCH;
      end
      HOLD: begin
        if (restart_s)                        state_nx = FETCH;
        else if (hs_s && (icode_r == 4'h0))   state_nx = HALTED;
        else if (hs_s)                        state_nx = FETCH;
        else                                  state_nx = HOLD;
      end
      HALTED, ERROR: begin
        if (restart_s) state_nx = FETCH;
        else           state_nx = state_r;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx;
  end

  // PC, byte counter and assembled instruction fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r    <= '0;
      cnt_r   <= 4'd0;
      len_r   <= 4'd0;
      icode_r <= 4'h0;
      ifun_r  <= 4'h0;
      ra_r    <= 4'hF;
      rb_r    <= 4'hF;
      valc_r  <= '0;
      valp_r  <= '0;
      valid_r <= 1'b0;
      halt_r  <= 1'b0;
      err_r   <= 1'b0;
    end else if (restart_s) begin
      pc_r    <= restart_pc_s;
      cnt_r   <= 4'd0;
      ra_r    <= 4'hF;
      rb_r    <= 4'hF;
      valc_r  <= '0;
      valid_r <= 1'b0;
      halt_r  <= 1'b0;
      err_r   <= 1'b0;
    end else if (hs_s) begin
      valid_r <= 1'b0;
      if (icode_r == 4'h0) begin
        halt_r <= 1'b1;
      end else begin
        pc_r   <= valp_r;
        cnt_r  <= 4'd0;
        ra_r   <= 4'hF;
        rb_r   <= 4'hF;
        valc_r <= '0;
      end
    end else if (state_r == FETCH) begin
      if (mem_en_s) cnt_r <= cnt_r + 4'd1;
      if (bad_icode_s || range_err_s) err_r <= 1'b1;
      if (cap_s) begin
        if (cnt_r == 4'd1) begin
          icode_r <= bus.mem_rdata[7:4];
          ifun_r  <= bus.mem_rdata[3:0];
          len_r   <= cur_len_s;
        end else if ((cnt_r == 4'd2) && ((cur_len_s == 4'd2) || (cur_len_s == 4'd10))) begin
          ra_r <= bus.mem_rdata[7:4];
          rb_r <= bus.mem_rdata[3:0];
        end else begin
          valc_r[{valc_k_s, 3'b000} +: 8] <= bus.mem_rdata;
        end
      end
      if (done_s) begin
        valid_r <= 1'b1;
        valp_r  <= pc_r + {{(DATA_WID-4){1'b0}}, cur_len_s};
      end
    end
  end

  assign bus.mem_en      = mem_en_s;
  assign bus.mem_addr    = want_s ? rd_addr_s : '0;
  assign bus.instr_valid = valid_r;
  assign bus.icode       = icode_r;
  assign bus.ifun        = ifun_r;
  assign bus.rA          = ra_r;
  assign bus.rB          = rb_r;
  assign bus.valC        = valc_r;
  assign bus.valP        = valp_r;
  assign bus.halt        = halt_r;
  assign bus.imem_error  = err_r;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: table of single instructions plus
// hand-written sequences for halt, stall, errors, redirect and reset.
module tb_fetch_sequencer;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  fetch_sequencer_if #(.DATA_WID(64)) bus ();

  fetch_sequencer #(.DATA_WID(64), .MEM_BYTES(2048)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [0:2047];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-wide synchronous memory, one cycle latency.
  always @(posedge clk) begin
    if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr[10:0]];
  end

  typedef struct {
    logic [63:0] pc;
    logic [79:0] bytes;
    int          len;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic load(input logic [63:0] a, input logic [79:0] b, input int n);
    for (int i = 0; i < n; i++) mem[11'(a + 64'(i))] = b[79-8*i -: 8];
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mem_en"}, 64'(bus.mem_en), 64'd0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 64'd0);
    chk({tag, "_valid"}, 64'(bus.instr_valid), 64'd0);
    chk({tag, "_icode"}, 64'(bus.icode), 64'd0);
    chk({tag, "_ifun"}, 64'(bus.ifun), 64'd0);
    chk({tag, "_rA"}, 64'(bus.rA), 64'hF);
    chk({tag, "_rB"}, 64'(bus.rB), 64'hF);
    chk({tag, "_valC"}, bus.valC, 64'd0);
    chk({tag, "_valP"}, bus.valP, 64'd0);
    chk({tag, "_halt"}, 64'(bus.halt), 64'd0);
    chk({tag, "_err"}, 64'(bus.imem_error), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.start          = 1'b0;
    bus.start_pc       = 64'd0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'd0;
    bus.instr_ready    = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;

    vecs[0] = '{64'h0,   {8'h10, 72'h0},                  1,  4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1};
    vecs[1] = '{64'h0,   80'h30F38877665544332211,        10, 4'h3, 4'h0, 4'hF, 4'h3, 64'h1122334455667788, 64'hA};
    vecs[2] = '{64'h20,  {16'h6012, 64'h0},               2,  4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h22};
    vecs[3] = '{64'h100, {72'h80_0001000000000000, 8'h0}, 9,  4'h8, 4'h0, 4'hF, 4'hF, 64'h100, 64'h109};
    vecs[4] = '{64'h7,   {72'h74_EFCDAB8967452301, 8'h0}, 9,  4'h7, 4'h4, 4'hF, 4'hF, 64'h0123456789ABCDEF, 64'h10};
    vecs[5] = '{64'h30,  80'h40570800000000000000,        10, 4'h4, 4'h0, 4'h5, 4'h7, 64'h8, 64'h3A};
    vecs[6] = '{64'h55,  {8'h90, 72'h0},                  1,  4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h56};
    vecs[7] = '{64'h200, {16'hB03F, 64'h0},               2,  4'hB, 4'h0, 4'h3, 4'hF, 64'h0, 64'h202};
    vecs[8] = '{64'h7FE, {16'h21AB, 64'h0},               2,  4'h2, 4'h1, 4'hA, 4'hB, 64'h0, 64'h800};
    vecs[9] = '{64'h400, 80'h50121020304050607080,        10, 4'h5, 4'h0, 4'h1, 4'h2, 64'h8070605040302010, 64'h40A};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_reset("rst");

    // Table: one instruction per vector, full read sequence and fields.
    for (int v = 0; v < 10; v++) begin
      do_reset();
      load(vecs[v].pc, vecs[v].bytes, vecs[v].len);
      bus.instr_ready = 1'b0;
      bus.start_pc = vecs[v].pc;
      bus.start = 1'b1;
      tick();
      for (int k = 0; k < vecs[v].len; k++) begin
        chk($sformatf("v%0d_rd%0d_en", v, k), 64'(bus.mem_en), 64'd1);
        chk($sformatf("v%0d_rd%0d_addr", v, k), bus.mem_addr, vecs[v].pc + 64'(k));
        tick();
      end
      chk($sformatf("v%0d_no_extra_rd", v), 64'(bus.mem_en), 64'd0);
      chk($sformatf("v%0d_early_valid", v), 64'(bus.instr_valid), 64'd0);
      tick();
      chk($sformatf("v%0d_valid", v), 64'(bus.instr_valid), 64'd1);
      chk($sformatf("v%0d_icode", v), 64'(bus.icode), 64'(vecs[v].icode));
      chk($sformatf("v%0d_ifun", v), 64'(bus.ifun), 64'(vecs[v].ifun));
      chk($sformatf("v%0d_rA", v), 64'(bus.rA), 64'(vecs[v].ra));
      chk($sformatf("v%0d_rB", v), 64'(bus.rB), 64'(vecs[v].rb));
      chk($sformatf("v%0d_valC", v), bus.valC, vecs[v].valc);
      chk($sformatf("v%0d_valP", v), bus.valP, vecs[v].valp);
      chk($sformatf("v%0d_err", v), 64'(bus.imem_error), 64'd0);
    end

    // nop then halt, back-to-back, then sticky halt.
    do_reset();
    mem[0] = 8'h10;
    mem[1] = 8'h00;
    bus.instr_ready = 1'b1;
    bus.start_pc = 64'd0;
    bus.start = 1'b1;
    tick();
    tick();
    tick();
    chk("nop_valid_c2", 64'(bus.instr_valid), 64'd1);
    chk("nop_icode", 64'(bus.icode), 64'h1);
    chk("nop_valP", bus.valP, 64'd1);
    tick();
    chk("halt_rd_en", 64'(bus.mem_en), 64'd1);
    chk("halt_rd_addr", bus.mem_addr, 64'd1);
    tick();
    tick();
    chk("halt_valid", 64'(bus.instr_valid), 64'd1);
    chk("halt_icode", 64'(bus.icode), 64'h0);
    chk("halt_valP", bus.valP, 64'd2);
    chk("halt_not_yet", 64'(bus.halt), 64'd0);
    tick();
    chk("halted_flag", 64'(bus.halt), 64'd1);
    chk("halted_valid", 64'(bus.instr_valid), 64'd0);
    chk("halted_mem_en", 64'(bus.mem_en), 64'd0);
    tick();
    chk("halted_sticky", 64'(bus.halt), 64'd1);
    chk("halted_mem_en2", 64'(bus.mem_en), 64'd0);

    // Decode stalls 5 cycles in HOLD on addq.
    do_reset();
    mem[0] = 8'h60;
    mem[1] = 8'h12;
    mem[2] = 8'h10;
    bus.instr_ready = 1'b0;
    bus.start_pc = 64'd0;
    bus.start = 1'b1;
    tick();
    tick();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d_valid", i), 64'(bus.instr_valid), 64'd1);
      chk($sformatf("stall%0d_mem_en", i), 64'(bus.mem_en), 64'd0);
      chk($sformatf("stall%0d_rA", i), 64'(bus.rA), 64'h1);
      chk($sformatf("stall%0d_rB", i), 64'(bus.rB), 64'h2);
      chk($sformatf("stall%0d_valP", i), bus.valP, 64'd2);
      tick();
    end
    bus.instr_ready = 1'b1;
    tick();
    chk("stall_next_en", 64'(bus.mem_en), 64'd1);
    chk("stall_next_addr", bus.mem_addr, 64'd2);
    chk("stall_next_valid", 64'(bus.instr_valid), 64'd0);

    // Invalid icode C0 at pc 4.
    do_reset();
    mem[4] = 8'hC0;
    bus.instr_ready = 1'b1;
    bus.start_pc = 64'd4;
    bus.start = 1'b1;
    tick();
    chk("inv_rd_addr", bus.mem_addr, 64'd4);
    tick();
    chk("inv_no_rd", 64'(bus.mem_en), 64'd0);
    chk("inv_err_not_yet", 64'(bus.imem_error), 64'd0);
    tick();
    chk("inv_err", 64'(bus.imem_error), 64'd1);
    chk("inv_valid", 64'(bus.instr_valid), 64'd0);
    tick();
    chk("inv_err_sticky", 64'(bus.imem_error), 64'd1);
    chk("inv_mem_en", 64'(bus.mem_en), 64'd0);
    chk("inv_valid2", 64'(bus.instr_valid), 64'd0);

    // jXX straddling the end of memory, then redirect out of ERROR.
    do_reset();
    mem[2045] = 8'h70;
    mem[2046] = 8'h11;
    mem[2047] = 8'h22;
    mem[64]   = 8'h10;
    bus.start_pc = 64'd2045;
    bus.start = 1'b1;
    tick();
    tick();
    tick();
    chk("oor_last_addr", bus.mem_addr, 64'd2047);
    chk("oor_last_en", 64'(bus.mem_en), 64'd1);
    tick();
    chk("oor_blocked_en", 64'(bus.mem_en), 64'd0);
    chk("oor_err_not_yet", 64'(bus.imem_error), 64'd0);
    tick();
    chk("oor_err", 64'(bus.imem_error), 64'd1);
    chk("oor_valid", 64'(bus.instr_valid), 64'd0);
    bus.redirect_pc = 64'h40;
    bus.redirect_valid = 1'b1;
    tick();
    chk("oor_redir_en", 64'(bus.mem_en), 64'd1);
    chk("oor_redir_addr", bus.mem_addr, 64'h40);
    chk("oor_redir_clr", 64'(bus.imem_error), 64'd0);

    // Redirect at the 4th byte of a call.
    do_reset();
    load(64'h10, {72'h80_1122334455667788, 8'h0}, 9);
    mem[64] = 8'h10;
    bus.instr_ready = 1'b1;
    bus.start_pc = 64'h10;
    bus.start = 1'b1;
    tick();
    tick();
    tick();
    tick();
    tick();
    bus.redirect_pc = 64'h40;
    bus.redirect_valid = 1'b1;
    tick();
    chk("redir_en", 64'(bus.mem_en), 64'd1);
    chk("redir_addr", bus.mem_addr, 64'h40);
    chk("redir_valid", 64'(bus.instr_valid), 64'd0);
    tick();
    tick();
    chk("redir_nop_valid", 64'(bus.instr_valid), 64'd1);
    chk("redir_nop_icode", 64'(bus.icode), 64'h1);
    chk("redir_nop_valP", bus.valP, 64'h41);
    chk("redir_nop_valC", bus.valC, 64'h0);

    // Asynchronous reset in the middle of an irmovq fetch.
    do_reset();
    load(64'h0, 80'h30F38877665544332211, 10);
    bus.instr_ready = 1'b0;
    bus.start_pc = 64'd0;
    bus.start = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk("mid_en", 64'(bus.mem_en), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    tick();
    chk("post_rst_idle_en", 64'(bus.mem_en), 64'd0);
    chk("post_rst_valid", 64'(bus.instr_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
